// File: rtl/bebidas_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : bebidas_pkg                                                  |
// | Description : States, drink codes and price lookup for the drink vendor.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package bebidas_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      PREP   = 3'd2,
      CAMBIO = 3'd3,
      DONE   = 3'd4
   } estado_t;

   localparam logic [2:0] SEL_BEBIDA_1 = 3'b001;
   localparam logic [2:0] SEL_BEBIDA_2 = 3'b010;
   localparam logic [2:0] SEL_BEBIDA_3 = 3'b011;
   localparam logic [2:0] SEL_BEBIDA_4 = 3'b100;

   typedef struct packed {
      logic       valido;
      logic [2:0] precio;
   } precio_t;

   // Price in units of 100; any code outside the table is flagged invalid.
   function automatic precio_t precio_de(input logic [2:0] sel);
      precio_t p;
      p.valido = 1'b1;
      p.precio = 3'd0;
      case (sel)
         SEL_BEBIDA_1: p.precio = 3'd3;
         SEL_BEBIDA_2: p.precio = 3'd5;
         SEL_BEBIDA_3: p.precio = 3'd4;
         SEL_BEBIDA_4: p.precio = 3'd2;
         default:      p.valido = 1'b0;
      endcase
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/detector_flanco.sv
// +----------------------------------------------------------------------------+
// | Module      : detector_flanco                                              |
// | Description : Generic 1-bit rising-edge detector with registered history.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module detector_flanco (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic flanco
);

   logic prev_q;
   logic prev_d;

   always_comb prev_d = d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_q <= 1'b0;
      else      prev_q <= prev_d;
   end

   assign flanco = d & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/dispensador_bebidas.sv
// +----------------------------------------------------------------------------+
// | Module      : dispensador_bebidas                                          |
// | Description : Credit accumulation, price check, timed preparation and     |
// |               change payout. REEMBOLSO_EN adds the cancelar refund input. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module dispensador_bebidas
   import bebidas_pkg::*;
#(
   parameter int CRED_W      = 5,
   parameter int PREP_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              suma100,
   input  logic              suma500,
   input  logic              enable,
   input  logic [2:0]        sel,
`ifdef REEMBOLSO_EN
   input  logic              cancelar,
`endif
   output logic [CRED_W-1:0] credito,
   output logic              preparando,
   output logic              vuelto100,
   output logic              listo,
   output logic              error_fondos
);

   localparam int                CNT_W    = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;
   localparam int                SUM_W    = CRED_W + 3;
   localparam logic [CNT_W-1:0]  CNT_INI  = CNT_W'(PREP_CYCLES - 1);
   localparam logic [CRED_W-1:0] CRED_MAX = {CRED_W{1'b1}};

   estado_t           state_q, state_d;
   logic [CRED_W-1:0] credito_q, credito_d;
   logic [2:0]        sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              flanco100, flanco500, flanco_en;
   logic              cancela;
   logic [SUM_W-1:0]  suma;
   precio_t           p;
   logic [CRED_W-1:0] precio_ext;
   logic              compra_ok;

   detector_flanco u_det100 (.clk(clk), .rst(rst), .d(suma100), .flanco(flanco100));
   detector_flanco u_det500 (.clk(clk), .rst(rst), .d(suma500), .flanco(flanco500));
   detector_flanco u_det_en (.clk(clk), .rst(rst), .d(enable),  .flanco(flanco_en));

`ifdef REEMBOLSO_EN
   assign cancela = cancelar && (credito_q != '0);
`else
   assign cancela = 1'b0;
`endif

   assign p          = precio_de(sel_q);
   assign precio_ext = CRED_W'(p.precio);
   assign compra_ok  = p.valido && (credito_q >= precio_ext);

   always_comb begin
      state_d   = state_q;
      credito_d = credito_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      suma      = '0;
      case (state_q)
         IDLE: begin
            // Coins arriving with the selection edge are credited before CHECK.
            suma = SUM_W'(credito_q) + SUM_W'(flanco100) + (flanco500 ? SUM_W'(5) : SUM_W'(0));
            credito_d = (suma > SUM_W'(CRED_MAX)) ? CRED_MAX : suma[CRED_W-1:0];
            if (cancela) begin
               state_d = CAMBIO;
            end else if (flanco_en) begin
               sel_d   = sel;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (compra_ok) begin
               credito_d = credito_q - precio_ext;
               cnt_d     = CNT_INI;
               state_d   = PREP;
            end else begin
               state_d = IDLE;
            end
         end
         PREP: begin
            if (cnt_q == '0) state_d = CAMBIO;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         CAMBIO: begin
            // The last decrement and the exit to DONE share a cycle.
            if (credito_q != '0) begin
               credito_d = credito_q - CRED_W'(1);
               if (credito_q == CRED_W'(1)) state_d = DONE;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         credito_q <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         credito_q <= credito_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
      end
   end

   assign credito      = credito_q;
   assign preparando   = (state_q == PREP);
   assign vuelto100    = (state_q == CAMBIO) && (credito_q != '0);
   assign listo        = (state_q == DONE);
   assign error_fondos = (state_q == CHECK) && !compra_ok;

endmodule

`default_nettype wire

// File: tb/tb_dispensador_bebidas.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_dispensador_bebidas                                       |
// | Description : Directed self-checking bench for dispensador_bebidas.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dispensador_bebidas;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       suma100 = 1'b0;
   logic       suma500 = 1'b0;
   logic       enable = 1'b0;
   logic [2:0] sel = 3'b000;
`ifdef REEMBOLSO_EN
   logic       cancelar = 1'b0;
`endif
   logic [4:0] credito;
   logic       preparando, vuelto100, listo, error_fondos;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   dispensador_bebidas #(.CRED_W(5), .PREP_CYCLES(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .suma100      (suma100),
      .suma500      (suma500),
      .enable       (enable),
      .sel          (sel),
`ifdef REEMBOLSO_EN
      .cancelar     (cancelar),
`endif
      .credito      (credito),
      .preparando   (preparando),
      .vuelto100    (vuelto100),
      .listo        (listo),
      .error_fondos (error_fondos)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic moneda(input logic m100, input logic m500);
      suma100 = m100;
      suma500 = m500;
      tick();
      suma100 = 1'b0;
      suma500 = 1'b0;
      tick();
   endtask

   // Samples at the current negedge, then advances; n cycles in total.
   task automatic run_ciclos(input int n, output int prep, output int vue, output int lis, output int err);
      prep = 0; vue = 0; lis = 0; err = 0;
      for (int i = 0; i < n; i++) begin
         prep += int'(preparando);
         vue  += int'(vuelto100);
         lis  += int'(listo);
         err  += int'(error_fondos);
         tick();
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total_cnt++;
      if ({credito, preparando, vuelto100, listo, error_fondos} !== 9'd0)
         $display("FAIL reset_outputs: got %b, expected 0", {credito, preparando, vuelto100, listo, error_fondos});
      else pass_cnt++;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_compra();
      int prep, vue, lis, err;
      moneda(1'b1, 1'b0);
      moneda(1'b1, 1'b0);
      moneda(1'b0, 1'b1);
      total_cnt++;
      if (credito !== 5'd7) $display("FAIL compra_credito_in: got %0d, expected 7", credito);
      else pass_cnt++;
      sel = 3'b010; enable = 1'b1;
      tick();
      enable = 1'b0;
      run_ciclos(30, prep, vue, lis, err);
      total_cnt++;
      if (prep != 8) $display("FAIL compra_prep: got %0d cycles, expected 8", prep); else pass_cnt++;
      total_cnt++;
      if (vue != 2) $display("FAIL compra_vuelto: got %0d pulses, expected 2", vue); else pass_cnt++;
      total_cnt++;
      if (lis != 1 || err != 0) $display("FAIL compra_listo_err: got listo=%0d err=%0d, expected 1 0", lis, err); else pass_cnt++;
      total_cnt++;
      if (credito !== 5'd0) $display("FAIL compra_credito_out: got %0d, expected 0", credito); else pass_cnt++;
   endtask

   task automatic test_fondos();
      int prep, vue, lis, err;
      moneda(1'b1, 1'b0);
      sel = 3'b001; enable = 1'b1;
      tick();
      enable = 1'b0;
      run_ciclos(8, prep, vue, lis, err);
      total_cnt++;
      if (err != 1) $display("FAIL fondos_error: got %0d pulses, expected 1", err); else pass_cnt++;
      total_cnt++;
      if (prep != 0 || lis != 0) $display("FAIL fondos_prep: got prep=%0d listo=%0d, expected 0 0", prep, lis); else pass_cnt++;
      total_cnt++;
      if (credito !== 5'd1) $display("FAIL fondos_credito: got %0d, expected 1", credito); else pass_cnt++;
   endtask

   task automatic test_invalida();
      int prep, vue, lis, err;
      for (int i = 0; i < 4; i++) moneda(1'b1, 1'b0);
      total_cnt++;
      if (credito !== 5'd5) $display("FAIL invalida_credito_in: got %0d, expected 5", credito); else pass_cnt++;
      sel = 3'b111; enable = 1'b1;
      tick();
      // enable stays high: a single edge must give a single error pulse.
      run_ciclos(10, prep, vue, lis, err);
      enable = 1'b0;
      tick();
      total_cnt++;
      if (err != 1 || prep != 0) $display("FAIL invalida_error: got err=%0d prep=%0d, expected 1 0", err, prep); else pass_cnt++;
      total_cnt++;
      if (credito !== 5'd5) $display("FAIL invalida_credito: got %0d, expected 5", credito); else pass_cnt++;
   endtask

   task automatic test_reset_prep();
      int prep, vue, lis, err;
      sel = 3'b100; enable = 1'b1;
      tick();
      enable = 1'b0;
      tick();
      tick(); tick(); tick();
      total_cnt++;
      if (preparando !== 1'b1 || credito !== 5'd3)
         $display("FAIL reset_prep_pre: got prep=%b credito=%0d, expected 1 3", preparando, credito);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++;
      if ({credito, preparando, vuelto100, listo, error_fondos} !== 9'd0)
         $display("FAIL reset_prep_async: got %b, expected 0", {credito, preparando, vuelto100, listo, error_fondos});
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      run_ciclos(12, prep, vue, lis, err);
      total_cnt++;
      if (prep != 0 || vue != 0 || lis != 0 || credito !== 5'd0)
         $display("FAIL reset_prep_idle: got prep=%0d vue=%0d listo=%0d credito=%0d, expected all 0", prep, vue, lis, credito);
      else pass_cnt++;
      moneda(1'b1, 1'b0);
      total_cnt++;
      if (credito !== 5'd1) $display("FAIL reset_prep_coin: got %0d, expected 1", credito); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int prep, vue, lis, err;
      // Both coins and the selection edge land in one cycle: 1 + 6 - 2 = 5 change.
      sel = 3'b100; suma100 = 1'b1; suma500 = 1'b1; enable = 1'b1;
      tick();
      suma100 = 1'b0; suma500 = 1'b0; enable = 1'b0;
      run_ciclos(30, prep, vue, lis, err);
      total_cnt++;
      if (prep != 8 || vue != 5) $display("FAIL b2b_seq: got prep=%0d vue=%0d, expected 8 5", prep, vue); else pass_cnt++;
      total_cnt++;
      if (lis != 1 || err != 0 || credito !== 5'd0)
         $display("FAIL b2b_end: got listo=%0d err=%0d credito=%0d, expected 1 0 0", lis, err, credito);
      else pass_cnt++;
   endtask

   task automatic test_saturacion();
      for (int i = 0; i < 6; i++) moneda(1'b0, 1'b1);
      total_cnt++;
      if (credito !== 5'd30) $display("FAIL sat_30: got %0d, expected 30", credito); else pass_cnt++;
      moneda(1'b0, 1'b1);
      total_cnt++;
      if (credito !== 5'd31) $display("FAIL sat_500: got %0d, expected 31", credito); else pass_cnt++;
      moneda(1'b1, 1'b0);
      total_cnt++;
      if (credito !== 5'd31) $display("FAIL sat_100: got %0d, expected 31", credito); else pass_cnt++;
   endtask

`ifdef REEMBOLSO_EN
   task automatic test_reembolso();
      int prep, vue, lis, err;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) moneda(1'b1, 1'b0);
      cancelar = 1'b1;
      tick();
      cancelar = 1'b0;
      run_ciclos(10, prep, vue, lis, err);
      total_cnt++;
      if (vue != 3 || lis != 1 || prep != 0)
         $display("FAIL reembolso_seq: got vue=%0d listo=%0d prep=%0d, expected 3 1 0", vue, lis, prep);
      else pass_cnt++;
      total_cnt++;
      if (credito !== 5'd0) $display("FAIL reembolso_credito: got %0d, expected 0", credito); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_compra();
      test_fondos();
      test_invalida();
      test_reset_prep();
      test_back_to_back();
      test_saturacion();
`ifdef REEMBOLSO_EN
      test_reembolso();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dispensador_bebidas.md
Name: dispensador_bebidas

Overview:
Downstream stage of the coin-adder FSM.
- Consumes its `suma100`, `suma500` and `enable` level outputs, plus the raw drink selection `sel`.
- Accumulates credit and checks it against the price of the selected drink.
- Runs a timed preparation sequence, then pays out change as 100-unit pulses.
- Sits between coin handling and the drink actuator and change-hopper drivers.

Parameters:
- CRED_W, 5: credit register width, in units of 100 (max credit 31 = 3100).
- PREP_CYCLES, 8: clock cycles `preparando` stays high per drink; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- suma100  input  1  level from coin FSM; a 0->1 edge means one 100 coin.
- suma500  input  1  level from coin FSM; a 0->1 edge means one 500 coin.
- enable  input  1  level from coin FSM; a 0->1 edge means a selection was made.
- sel  input  3  drink code; sampled on the `enable` 0->1 edge.
- credito  output  CRED_W  current credit, in units of 100.
- preparando  output  1  high during preparation.
- vuelto100  output  1  one-cycle pulse per 100 of change returned.
- listo  output  1  one-cycle pulse when the sequence completes.
- error_fondos  output  1  one-cycle pulse on insufficient credit or invalid selection.

Behaviour:
- Reset (`rst` low, asynchronous):
  - state = IDLE; `credito`, all outputs and the edge-detect history registers = 0.
  - Reset mid-preparation or mid-change aborts immediately and discards credit.
- Edge detection: 1-cycle registered history of `suma100`, `suma500`, `enable`. An edge is current high AND previous low.
- Price table, in units of 100:
  - 001 = 3
  - 010 = 5
  - 011 = 4
  - 100 = 2
  - 000, 101, 110, 111 = invalid
- IDLE:
  - `suma100` edge: `credito` += 1. `suma500` edge: `credito` += 5. Both in the same cycle: += 6.
  - Addition saturates at 2^CRED_W-1; excess is lost.
  - `enable` edge: latch `sel` into `sel_q` and go to CHECK.
  - A coin edge in the same cycle as the `enable` edge is credited before CHECK.
- CHECK (1 cycle):
  - `sel_q` invalid: pulse `error_fondos`, go to IDLE, credit kept.
  - `credito` < price: pulse `error_fondos`, go to IDLE, credit kept.
  - Otherwise: `credito` -= price, go to PREP.
- PREP:
  - `preparando` = 1 for exactly PREP_CYCLES cycles (internal down-counter), then go to CAMBIO.
- CAMBIO:
  - While `credito` != 0: `vuelto100` = 1 and `credito` -= 1, once per cycle.
  - When `credito` == 0 on entry or after the last decrement, go to DONE.
  - Zero change means zero cycles of `vuelto100`.
- DONE (1 cycle): `listo` = 1, then IDLE.
- Coin and `enable` edges outside IDLE are discarded; the history registers still update.
- `enable` held high from upstream causes no retrigger; a new low->high edge is needed.
- All outputs are registered or decoded directly from state. No combinational path from inputs to outputs.

Optional Feature:
- REEMBOLSO_EN defined:
  - Adds input port `cancelar` (1 bit, level).
  - `cancelar` high in IDLE with `credito` != 0 goes to CAMBIO: the full credit is returned as `vuelto100` pulses, then DONE.
  - `cancelar` outside IDLE is ignored.
  - `cancelar` and an `enable` edge in the same cycle: `cancelar` wins.
- Undefined: no `cancelar` port; credit is only returned as change after a purchase.

Decomposition:
- Package `bebidas_pkg`:
  - state enum {IDLE, CHECK, PREP, CAMBIO, DONE}.
  - drink code localparams.
  - price function mapping sel to price plus a valid flag.
- Sub-module `detector_flanco`: generic 1-bit rising-edge detector, instantiated 3x, clocked by `clk` with async active-low `rst`.

Test Plan:
- Two `suma100` edges, one `suma500` edge, then `enable` edge with `sel`=010 -> `credito` 7 -> 2; `preparando` high 8 cycles; exactly 2 `vuelto100` pulses; `listo` pulse; `credito`=0.
- One `suma100` edge, `enable` edge with `sel`=001 -> `error_fondos` one pulse; `credito` stays 1; no `preparando`.
- `enable` edge with `sel`=111 and `credito`=5 -> `error_fondos` pulse; `credito` stays 5.
- Seven `suma500` edges (CRED_W=5) -> `credito` saturates at 31, not 35.
- `rst` asserted low in the 4th PREP cycle -> all outputs 0 and `credito`=0 asynchronously; state IDLE after release.
- REEMBOLSO_EN: `credito`=3, `cancelar` high in IDLE -> 3 consecutive `vuelto100` pulses, `listo` pulse, `credito`=0.
